// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// state encoding, counter sizing and the digit-count sizing rule.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_N      = 8;
  localparam int unsigned DEF_DIGITS = 3;

  // Bit-counter width: must hold the value n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // True when d decimal digits can represent every n-bit unsigned value.
  function automatic bit digits_fit(input int unsigned n, input int unsigned d);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < d; i++) p = p * 64'd10;
    return p > (64'd1 << n);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a requester and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [N-1:0]          bin;
  logic                  signed_mode;
  logic                  busy;
  logic                  done;
  logic                  neg;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin, signed_mode, input busy, done, neg, bcd);
  modport slave  (input start, bin, signed_mode, output busy, done, neg, bcd);
endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Single-digit shift-add-3 correction: digits of 5 or more get +3 before the shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] fixed_c
);
  assign fixed_c = (digit >= 4'd5) ? (digit + 4'd3) : digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per clock (double dabble),
// with optional two's-complement input giving sign plus magnitude.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic             clk,
  input  logic             aclr,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = cnt_width(N);

  if (!digits_fit(N, DIGITS)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for N-bit input");
  end

  state_t          state, state_nx;
  logic [N-1:0]    operand, operand_nx, mag;
  logic [BW-1:0]   scratch, scratch_nx, corr;
  logic [BW-1:0]   bcd_r, bcd_nx;
  logic [CW-1:0]   count, count_nx;
  logic            neg_int, neg_int_nx, sign;
  logic            neg_r, neg_nx;
  logic            busy_r, busy_nx;
  logic            done_r, done_nx;
  logic [BW+N-1:0] shifted;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_add3 u_add3 (
      .digit   (scratch[4*k +: 4]),
      .fixed_c (corr[4*k +: 4])
    );
  end

  assign shifted = {corr, operand} << 1;
  assign sign    = bus.signed_mode & bus.bin[N-1];
  // -2**(N-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign mag     = sign ? N'(-bus.bin) : bus.bin;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state   <= ST_IDLE;
      operand <= '0;
      scratch <= '0;
      count   <= '0;
      neg_int <= 1'b0;
      neg_r   <= 1'b0;
      bcd_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      operand <= operand_nx;
      scratch <= scratch_nx;
      count   <= count_nx;
      neg_int <= neg_int_nx;
      neg_r   <= neg_nx;
      bcd_r   <= bcd_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
    end
  end

  // Results are loaded on the last shift so they are valid while done is high.
  always_comb begin
    state_nx   = state;
    operand_nx = operand;
    scratch_nx = scratch;
    count_nx   = count;
    neg_int_nx = neg_int;
    neg_nx     = neg_r;
    bcd_nx     = bcd_r;
    busy_nx    = busy_r;
    done_nx    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_nx = 1'b0;
        if (bus.start) begin
          operand_nx = mag;
          neg_int_nx = sign;
          scratch_nx = '0;
          count_nx   = CW'(N);
          busy_nx    = 1'b1;
          state_nx   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy_nx    = 1'b1;
        scratch_nx = shifted[BW+N-1:N];
        operand_nx = shifted[N-1:0];
        count_nx   = count - CW'(1);
        if (count == CW'(1)) begin
          bcd_nx   = shifted[BW+N-1:N];
          neg_nx   = neg_int;
          done_nx  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.neg  = neg_r;
  assign bus.bcd  = bcd_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and sweep bench for bin_to_bcd_seq with a result scoreboard.
module tb_bin_to_bcd_seq;

  localparam int unsigned N      = 8;
  localparam int unsigned DIGITS = 3;

  logic clk;
  logic aclr;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   done_count;
  int   lat;
  int   base;
  logic [12:0] sb[$];
  int   done_cyc[$];

  bin_to_bcd_seq_if #(.N(N), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.N(N), .DIGITS(DIGITS)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] ref_model(input logic [7:0] b, input logic sm);
    int   m;
    logic n;
    n = sm & b[7];
    m = n ? (256 - int'(b)) : int'(b);
    return {n, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (aclr && bus.done) begin
      done_count++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, bus.done}, 32'd0);
      end else begin
        logic [12:0] e;
        e = sb.pop_front();
        check("bcd", {20'd0, bus.bcd}, {20'd0, e[11:0]});
        check("neg", {31'd0, bus.neg}, {31'd0, e[12]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input logic [7:0] b, input logic sm, input bit push);
    bus.bin         = b;
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    if (push) sb.push_back(ref_model(b, sm));
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      l++;
      if (bus.done) break;
      check("busy_while_converting", {31'd0, bus.busy}, 32'd1);
    end
    if (!bus.done) check("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic run(input logic [7:0] b, input logic sm);
    int l;
    start_conv(b, sm, 1'b1);
    wait_done(l);
    check("latency", l, N);
    tick();
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    done_count      = 0;
    aclr            = 1'b0;
    bus.start       = 1'b0;
    bus.bin         = '0;
    bus.signed_mode = 1'b0;

    // Reset values
    #3;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_neg",  {31'd0, bus.neg},  32'd0);
    check("rst_bcd",  {20'd0, bus.bcd},  32'd0);
    tick();
    tick();
    aclr = 1'b1;
    tick();

    // Zero, then post-done idle
    start_conv(8'd0, 1'b0, 1'b1);
    wait_done(lat);
    check("latency_zero", lat, N);
    tick();
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_done", {31'd0, bus.done}, 32'd0);

    // Unsigned and signed corner values
    run(8'd255, 1'b0);
    run(8'd100, 1'b0);
    run(8'h80, 1'b1);
    run(8'hFF, 1'b1);
    run(8'h7F, 1'b1);

    // Start while busy is ignored
    base = done_count;
    start_conv(8'd42, 1'b0, 1'b1);
    repeat (3) begin
      tick();
      check("busy_mid", {31'd0, bus.busy}, 32'd1);
    end
    bus.bin   = 8'd99;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat);
    check("latency_after_ignored", lat, 4);
    repeat (12) tick();
    check("single_done", done_count - base, 1);
    check("hold_bcd", {20'd0, bus.bcd}, 32'h042);

    // Reset mid-conversion aborts it
    base = done_count;
    start_conv(8'd200, 1'b0, 1'b0);
    repeat (4) tick();
    aclr = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_neg",  {31'd0, bus.neg},  32'd0);
    check("abort_bcd",  {20'd0, bus.bcd},  32'd0);
    tick();
    tick();
    aclr = 1'b1;
    repeat (12) tick();
    check("abort_no_done", done_count - base, 0);
    run(8'd7, 1'b0);

    // Back-to-back spacing
    done_cyc.delete();
    run(8'd200, 1'b0);
    run(8'd5, 1'b0);
    run(8'd63, 1'b0);
    check("b2b_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("b2b_gap0", done_cyc[1] - done_cyc[0], N + 2);
      check("b2b_gap1", done_cyc[2] - done_cyc[1], N + 2);
    end

    // Full sweeps
    for (int i = 0; i < 256; i++) run(8'(i), 1'b0);
    for (int i = 0; i < 256; i++) run(8'(i), 1'b1);

    repeat (4) tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
